// File: rtl/auto_machine.sv
// Washing-machine sequencer: a Moore FSM with a soap/rinse pass register.
// Build option: define AUTO_MACHINE_RINSE_EN to add the rinse pass after the soap drain.
module auto_machine (
  input  logic clk,
  input  logic reset,
  input  logic door_close,
  input  logic start,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_value_on,
  output logic drain_value_on,
  output logic done,
  output logic soap_wash,
  output logic water_wash
);

  // state      | meaning
  // S_IDLE     | waiting for start, everything off
  // S_CHECK    | start seen, waiting for the door to be shut
  // S_FILL     | door locked, inlet valve open
  // S_ADD_DET  | dispensing detergent (soap pass only)
  // S_CYCLE    | agitating
  // S_DRAIN    | drain valve open
  // S_SPIN     | final spin with drain open
  // S_DONE     | wash complete, waiting for start to be released
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FILL    = 3'd2,
    S_ADD_DET = 3'd3,
    S_CYCLE   = 3'd4,
    S_DRAIN   = 3'd5,
    S_SPIN    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t state_q, state_d;
  logic   pass_q, pass_d;    // 0 = soap pass, 1 = rinse pass

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  // Each state looks only at its own exit input.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          pass_d  = 1'b0;
        end
      end
      S_CHECK: begin
        if (door_close) state_d = S_FILL;
      end
      S_FILL: begin
        if (filled) state_d = pass_q ? S_CYCLE : S_ADD_DET;
      end
      S_ADD_DET: begin
        if (detergent_added) state_d = S_CYCLE;
      end
      S_CYCLE: begin
        if (cycle_timeout) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
`ifdef AUTO_MACHINE_RINSE_EN
          if (!pass_q) begin
            state_d = S_FILL;
            pass_d  = 1'b1;
          end else begin
            state_d = S_SPIN;
          end
`else
          state_d = S_SPIN;
`endif
        end
      end
      S_SPIN: begin
        if (spin_timeout) state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    done           = 1'b0;
    soap_wash      = 1'b0;
    water_wash     = 1'b0;
    case (state_q)
      S_FILL: begin
        door_lock     = 1'b1;
        fill_value_on = 1'b1;
`ifdef AUTO_MACHINE_RINSE_EN
        water_wash    = pass_q;
`endif
      end
      S_ADD_DET: begin
        door_lock = 1'b1;
        soap_wash = ~pass_q;
      end
      S_CYCLE: begin
        door_lock  = 1'b1;
        motor_on   = 1'b1;
        soap_wash  = ~pass_q;
`ifdef AUTO_MACHINE_RINSE_EN
        water_wash = pass_q;
`endif
      end
      S_DRAIN: begin
        door_lock      = 1'b1;
        drain_value_on = 1'b1;
        soap_wash      = ~pass_q;
`ifdef AUTO_MACHINE_RINSE_EN
        water_wash     = pass_q;
`endif
      end
      S_SPIN: begin
        door_lock      = 1'b1;
        motor_on       = 1'b1;
        drain_value_on = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        door_lock = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_auto_machine.sv
// Scoreboard bench for auto_machine: stimulus/expected pairs are queued per scenario
// and each expected output vector is popped and compared one edge after its stimulus.
module tb_auto_machine;

  logic clk = 1'b0;
  logic reset, door_close, start, filled, detergent_added;
  logic cycle_timeout, drained, spin_timeout;
  logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  // stimulus: {reset, start, door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout}
  logic [7:0] stim_q[$];
  logic [6:0] exp_q[$];

  // outputs: {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash}
  localparam logic [6:0] O_OFF    = 7'b0000000;
  localparam logic [6:0] O_FILL   = 7'b1010000;
  localparam logic [6:0] O_FILL_R = 7'b1010001;
  localparam logic [6:0] O_ADD    = 7'b1000010;
  localparam logic [6:0] O_CYC_S  = 7'b1100010;
  localparam logic [6:0] O_CYC_R  = 7'b1100001;
  localparam logic [6:0] O_DRN_S  = 7'b1001010;
  localparam logic [6:0] O_DRN_R  = 7'b1001001;
  localparam logic [6:0] O_SPIN   = 7'b1101000;
  localparam logic [6:0] O_DONE   = 7'b0000100;

  always #5 clk = ~clk;

  assign outs = {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};

  auto_machine dut (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .filled(filled),
    .detergent_added(detergent_added), .cycle_timeout(cycle_timeout), .drained(drained),
    .spin_timeout(spin_timeout), .door_lock(door_lock), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on), .done(done),
    .soap_wash(soap_wash), .water_wash(water_wash)
  );

  task automatic drive(input logic [7:0] s);
    {reset, start, door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout} = s;
  endtask

  task automatic add(input logic [7:0] s, input logic [6:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Inputs raised one by one and then held high, ending with start released in DONE.
  task automatic queue_full_run();
    add(8'b0_1100000, O_OFF);      // IDLE -> CHECK_DOOR
    add(8'b0_1100000, O_FILL);
    add(8'b0_1110000, O_ADD);
    add(8'b0_1111000, O_CYC_S);
    add(8'b0_1111100, O_DRN_S);
`ifdef AUTO_MACHINE_RINSE_EN
    add(8'b0_1111110, O_FILL_R);
    add(8'b0_1111110, O_CYC_R);
    add(8'b0_1111110, O_DRN_R);
    add(8'b0_1111110, O_SPIN);
`else
    add(8'b0_1111110, O_SPIN);
    add(8'b0_1111110, O_SPIN);     // no spin_timeout yet: must stay in SPIN
`endif
    add(8'b0_1111111, O_DONE);
    add(8'b0_1111111, O_DONE);     // start still high: hold
    add(8'b0_1111111, O_DONE);
    add(8'b0_0111111, O_OFF);      // start released -> IDLE
    add(8'b0_0111111, O_OFF);
  endtask

  task automatic test_reset();
    logic [6:0] e;
    add(8'b1_1010101, O_OFF);
    add(8'b1_1111111, O_OFF);
    add(8'b0_0000000, O_OFF);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset: outputs %b, expected %b", outs, e);
      end
    end
  endtask

  task automatic test_full_run();
    logic [6:0] e;
    int step = 0;
    queue_full_run();
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL full_run step %0d: outputs %b, expected %b", step, outs, e);
      end
      if (soap_wash === 1'b1 && water_wash === 1'b1) begin
        errors++;
        $display("FAIL full_run step %0d: soap_wash and water_wash both high", step);
      end
      step++;
    end
  endtask

  // Second run without reset: pass must have been cleared by the IDLE start.
  task automatic test_back_to_back();
    logic [6:0] e;
    int step = 0;
    queue_full_run();
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: outputs %b, expected %b", step, outs, e);
      end
      step++;
    end
  endtask

  // Door stays open for 5 cycles; start is dropped meanwhile to show it is ignored.
  task automatic test_door_open();
    logic [6:0] e;
    int step = 0;
    add(8'b0_1000000, O_OFF);      // -> CHECK_DOOR
    for (int i = 0; i < 5; i++)
      add((i < 2) ? 8'b0_1011111 : 8'b0_0011111, O_OFF);
    add(8'b0_0100000, O_FILL);     // door shut -> FILL in one edge
    add(8'b0_0000000, O_FILL);     // door_close ignored once locked
    add(8'b1_0000000, O_OFF);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL door_open step %0d: outputs %b, expected %b", step, outs, e);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid_cycle();
    logic [6:0] e;
    int step = 0;
    add(8'b0_1100000, O_OFF);
    add(8'b0_1100000, O_FILL);
    add(8'b0_0010000, O_ADD);      // start/door dropped: ignored
    add(8'b0_0011000, O_CYC_S);
    add(8'b1_1111111, O_OFF);      // reset wins over every input
    add(8'b0_1000000, O_OFF);      // first edge out of reset sees start
    add(8'b0_0110000, O_FILL);     // so CHECK_DOOR exits on this edge
    add(8'b0_0010000, O_ADD);      // pass back to soap after reset
    add(8'b1_0000000, O_OFF);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset_mid_cycle step %0d: outputs %b, expected %b", step, outs, e);
      end
      step++;
    end
  endtask

  initial begin
    drive(8'b1_0000000);
    @(negedge clk);
    test_reset();
    test_full_run();
    test_back_to_back();
    test_door_open();
    test_reset_mid_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
